// File: rtl/zbt_proc_writer_if.sv
// Bus bundle for zbt_proc_writer.
//   Capture side : two_proc_pixs, proc_pix_addr (from colour reduction)
//   Arbiter side : wr_slot (write grant for ZBT bank 1)
//   ZBT side     : zbt_addr, zbt_we, zbt_write_data
//   Status       : fifo_count, overflow, drop_count
// slave is the writer's view, master is the view of whoever drives it.
interface zbt_proc_writer_if #(
  parameter int PTR_W = 3
);
  logic [35:0]    two_proc_pixs;
  logic [18:0]    proc_pix_addr;
  logic           wr_slot;
  logic [18:0]    zbt_addr;
  logic           zbt_we;
  logic [35:0]    zbt_write_data;
  logic [PTR_W:0] fifo_count;
  logic           overflow;
  logic [7:0]     drop_count;

  modport slave (
    input  two_proc_pixs, proc_pix_addr, wr_slot,
    output zbt_addr, zbt_we, zbt_write_data, fifo_count, overflow, drop_count
  );

  modport master (
    output two_proc_pixs, proc_pix_addr, wr_slot,
    input  zbt_addr, zbt_we, zbt_write_data, fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/zbt_proc_writer.sv
// zbt_proc_writer: buffers processed pixel pairs and writes them into ZBT
// bank 1 during arbiter-granted write slots, using late-write timing
// (address/WE first, data WR_LAT cycles later).
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - zbt_proc_writer_if.slave (capture inputs, wr_slot grant,
//           ZBT address/WE/data outputs, occupancy and drop status)
module zbt_proc_writer #(
  parameter int          DEPTH    = 8,
  parameter int          PTR_W    = 3,
  parameter int          WR_LAT   = 2,
  parameter logic [18:0] ADDR_RST = 19'h7FFFF
) (
  input logic              clk,
  input logic              reset,
  zbt_proc_writer_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [54:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [18:0]      last_addr;
  logic [7:0]       drops;
  logic [35:0]      data_pn [WR_LAT];
  logic             vld_pn  [WR_LAT];

  logic        push_req;
  logic        pop;
  logic        accept;
  logic        full;
  logic        empty;
  logic [54:0] head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pair is new whenever the address moves; a pop in the same cycle frees
  // a slot for it even when the FIFO is full. Pops only see registered
  // occupancy, so a pair cannot leave in the cycle it arrives.
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    push_req = (bus.proc_pix_addr != last_addr);
    pop      = bus.wr_slot && !empty;
    accept   = push_req && (!full || pop);
    head     = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {bus.proc_pix_addr, bus.two_proc_pixs};
  end

  // Stage p0: FIFO control and the address/WE phase of the ZBT write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_addr    <= ADDR_RST;
      drops        <= '0;
      bus.overflow <= 1'b0;
      bus.zbt_we   <= 1'b0;
      bus.zbt_addr <= '0;
    end else begin
      if (push_req) last_addr <= bus.proc_pix_addr;
      if (accept)   wr_ptr    <= wr_ptr + 1'b1;
      if (pop)      rd_ptr    <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !accept) begin
        bus.overflow <= 1'b1;
        drops        <= sat_inc8(drops);
      end
      bus.zbt_we <= pop;
      if (pop) bus.zbt_addr <= head[54:36];
    end
  end

  // Stages p0..p(WR_LAT-1) then output: data trails the WE by WR_LAT cycles.
  // Clearing the valids on reset abandons any write already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < WR_LAT; k++) begin
        data_pn[k] <= '0;
        vld_pn[k]  <= 1'b0;
      end
      bus.zbt_write_data <= '0;
    end else begin
      data_pn[0] <= head[35:0];
      vld_pn[0]  <= pop;
      for (int k = 1; k < WR_LAT; k++) begin
        data_pn[k] <= data_pn[k-1];
        vld_pn[k]  <= vld_pn[k-1];
      end
      bus.zbt_write_data <= vld_pn[WR_LAT-1] ? data_pn[WR_LAT-1] : '0;
    end
  end

  assign bus.fifo_count = count;
  assign bus.drop_count = drops;

endmodule

// File: tb/tb_zbt_proc_writer.sv
module tb_zbt_proc_writer;
  localparam int          DEPTH    = 8;
  localparam int          PTR_W    = 3;
  localparam int          WR_LAT   = 2;
  localparam logic [18:0] ADDR_RST = 19'h7FFFF;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zbt_proc_writer_if #(.PTR_W(PTR_W)) bus();

  zbt_proc_writer #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .WR_LAT(WR_LAT), .ADDR_RST(ADDR_RST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of pending {addr,data}, and a map from cycle
  // number to the data word due on zbt_write_data in that cycle.
  logic [54:0] mq [$];
  logic [18:0] m_last;
  int          m_drops;
  bit          m_ovf;
  bit          m_we;
  logic [18:0] m_addr;
  logic [35:0] due [int];
  int          cyc = 0;

  function automatic logic [35:0] exp_wdata();
    return due.exists(cyc) ? due[cyc] : 36'd0;
  endfunction

  function automatic logic [35:0] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    mq.delete();
    due.delete();
    m_last  = ADDR_RST;
    m_drops = 0;
    m_ovf   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // leave time at 1 unit past the edge for sampling.
  task automatic step(input logic [18:0] a, input logic [35:0] d, input bit s);
    bit          pop;
    logic [54:0] hd;
    bus.proc_pix_addr = a;
    bus.two_proc_pixs = d;
    bus.wr_slot       = s;
    @(posedge clk);
    cyc++;
    pop  = s && (mq.size() > 0);
    m_we = pop;
    if (pop) begin
      hd     = mq.pop_front();
      m_addr = hd[54:36];
      due[cyc + WR_LAT] = hd[35:0];
    end
    if (a != m_last) begin
      m_last = a;
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.proc_pix_addr = '0;
    bus.two_proc_pixs = '0;
    bus.wr_slot       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.zbt_addr !== 19'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.zbt_addr); end
    checks++; if (bus.zbt_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bus.zbt_we); end
    checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.zbt_write_data); end
    checks++; if (bus.fifo_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd0) begin failures++; $display("FAIL rst_drops got=%0d exp=0", bus.drop_count); end
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_hold_capture();
    for (int i = 0; i < 5; i++) begin
      step(19'h00010, 36'h3_0000_0001, 1'b0);
      checks++; if (bus.zbt_we !== 1'b0) begin failures++; $display("FAIL hold_we cyc%0d got=%b exp=0", i, bus.zbt_we); end
    end
    checks++; if (bus.fifo_count !== 4'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", bus.fifo_count); end
  endtask

  task automatic test_single_write();
    step(19'h00010, 36'h3_0000_0001, 1'b1);
    checks++; if (bus.zbt_we !== 1'b1) begin failures++; $display("FAIL single_we got=%b exp=1", bus.zbt_we); end
    checks++; if (bus.zbt_addr !== 19'h00010) begin failures++; $display("FAIL single_addr got=%h exp=00010", bus.zbt_addr); end
    checks++; if (bus.fifo_count !== 4'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", bus.fifo_count); end
    step(19'h00010, 36'h3_0000_0001, 1'b0);
    checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL single_wdata_n2 got=%h exp=0", bus.zbt_write_data); end
    checks++; if (bus.zbt_we !== 1'b0) begin failures++; $display("FAIL single_we_n2 got=%b exp=0", bus.zbt_we); end
    step(19'h00010, 36'h3_0000_0001, 1'b0);
    checks++; if (bus.zbt_write_data !== 36'h3_0000_0001) begin failures++; $display("FAIL single_wdata_n3 got=%h exp=300000001", bus.zbt_write_data); end
    step(19'h00010, 36'h3_0000_0001, 1'b0);
    checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL single_wdata_n4 got=%h exp=0", bus.zbt_write_data); end
  endtask

  task automatic test_overflow();
    logic [35:0] dat [10];
    logic [35:0] ew;
    for (int i = 0; i < 10; i++) begin
      dat[i] = rnd36();
      step(19'(i + 1), dat[i], 1'b0);
    end
    checks++; if (bus.fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", bus.fifo_count); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drops got=%0d exp=2", bus.drop_count); end
    for (int k = 0; k < 8 + WR_LAT + 1; k++) begin
      step(19'd10, rnd36(), 1'b1);
      checks++; if (bus.zbt_we !== (k < 8)) begin failures++; $display("FAIL drain_we k%0d got=%b exp=%b", k, bus.zbt_we, (k < 8)); end
      if (k < 8) begin
        checks++; if (bus.zbt_addr !== 19'(k + 1)) begin failures++; $display("FAIL drain_addr k%0d got=%h exp=%h", k, bus.zbt_addr, 19'(k + 1)); end
      end
      ew = (k >= WR_LAT && k - WR_LAT < 8) ? dat[k - WR_LAT] : 36'd0;
      checks++; if (bus.zbt_write_data !== ew) begin failures++; $display("FAIL drain_wdata k%0d got=%h exp=%h", k, bus.zbt_write_data, ew); end
    end
    checks++; if (bus.fifo_count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) step(19'h00100 + 19'(i), rnd36(), 1'b0);
    checks++; if (bus.fifo_count !== 4'd8) begin failures++; $display("FAIL fpp_fill got=%0d exp=8", bus.fifo_count); end
    step(19'h00200, rnd36(), 1'b1);
    checks++; if (bus.fifo_count !== 4'd8) begin failures++; $display("FAIL fpp_count got=%0d exp=8", bus.fifo_count); end
    checks++; if (bus.drop_count !== 8'd2) begin failures++; $display("FAIL fpp_drops got=%0d exp=2", bus.drop_count); end
    checks++; if (bus.zbt_addr !== 19'h00100) begin failures++; $display("FAIL fpp_addr got=%h exp=00100", bus.zbt_addr); end
    for (int k = 0; k < 8 + WR_LAT + 1; k++) begin
      step(19'h00200, rnd36(), 1'b1);
      checks++; if (bus.zbt_we !== m_we) begin failures++; $display("FAIL fpp_we k%0d got=%b exp=%b", k, bus.zbt_we, m_we); end
      checks++; if (bus.zbt_addr !== m_addr) begin failures++; $display("FAIL fpp_addr k%0d got=%h exp=%h", k, bus.zbt_addr, m_addr); end
      checks++; if (bus.zbt_write_data !== exp_wdata()) begin failures++; $display("FAIL fpp_wdata k%0d got=%h exp=%h", k, bus.zbt_write_data, exp_wdata()); end
    end
  endtask

  task automatic test_random();
    logic [18:0] a;
    bit          s;
    for (int i = 0; i < 400; i++) begin
      a = 19'h00300 + 19'($urandom_range(0, 3));
      s = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(a, rnd36(), s);
      checks++; if (bus.zbt_we !== m_we) begin failures++; $display("FAIL rnd_we i%0d got=%b exp=%b", i, bus.zbt_we, m_we); end
      checks++; if (bus.zbt_addr !== m_addr) begin failures++; $display("FAIL rnd_addr i%0d got=%h exp=%h", i, bus.zbt_addr, m_addr); end
      checks++; if (bus.zbt_write_data !== exp_wdata()) begin failures++; $display("FAIL rnd_wdata i%0d got=%h exp=%h", i, bus.zbt_write_data, exp_wdata()); end
      checks++; if (bus.fifo_count !== 4'(mq.size())) begin failures++; $display("FAIL rnd_count i%0d got=%0d exp=%0d", i, bus.fifo_count, mq.size()); end
      checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf i%0d got=%b exp=%b", i, bus.overflow, m_ovf); end
      checks++; if (bus.drop_count !== 8'(m_drops)) begin failures++; $display("FAIL rnd_drops i%0d got=%0d exp=%0d", i, bus.drop_count, m_drops); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 320; i++) step(19'h01000 + 19'(i), rnd36(), 1'b0);
    checks++; if (bus.drop_count !== 8'd255) begin failures++; $display("FAIL sat_drops got=%0d exp=255", bus.drop_count); end
    checks++; if (bus.drop_count !== 8'(m_drops)) begin failures++; $display("FAIL sat_model got=%0d exp=%0d", bus.drop_count, m_drops); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", bus.overflow); end
    checks++; if (bus.fifo_count !== 4'd8) begin failures++; $display("FAIL sat_count got=%0d exp=8", bus.fifo_count); end
  endtask

  task automatic test_reset_midflight();
    logic [18:0] held;
    held = 19'h01000 + 19'd319;
    step(held, rnd36(), 1'b1);
    checks++; if (bus.zbt_we !== 1'b1) begin failures++; $display("FAIL mid_we_pre got=%b exp=1", bus.zbt_we); end
    reset = 1'b1;
    #1;
    checks++; if (bus.zbt_we !== 1'b0) begin failures++; $display("FAIL mid_we_async got=%b exp=0", bus.zbt_we); end
    checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL mid_wdata_async got=%h exp=0", bus.zbt_write_data); end
    checks++; if (bus.fifo_count !== 4'd0) begin failures++; $display("FAIL mid_count_async got=%0d exp=0", bus.fifo_count); end
    checks++; if (bus.drop_count !== 8'd0) begin failures++; $display("FAIL mid_drops_async got=%0d exp=0", bus.drop_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf_async got=%b exp=0", bus.overflow); end
    model_reset();
    bus.wr_slot = 1'b0;
    for (int k = 0; k < WR_LAT + 1; k++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL mid_wdata_hold k%0d got=%h exp=0", k, bus.zbt_write_data); end
    end
    reset = 1'b0;
    for (int k = 0; k < WR_LAT + 2; k++) begin
      step(held, rnd36(), 1'b0);
      checks++; if (bus.zbt_we !== 1'b0) begin failures++; $display("FAIL mid_we_post k%0d got=%b exp=0", k, bus.zbt_we); end
      checks++; if (bus.zbt_write_data !== 36'd0) begin failures++; $display("FAIL mid_wdata_post k%0d got=%h exp=0", k, bus.zbt_write_data); end
      checks++; if (bus.fifo_count !== 4'd1) begin failures++; $display("FAIL mid_recapture k%0d got=%0d exp=1", k, bus.fifo_count); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hold_capture();
    test_single_write();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_saturation();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
